// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-access stage behind the ALU. Accepts one load/store from EX, issues a
//   single word-aligned data-memory request with byte enables, waits for grant
//   (and read data for loads), extends the loaded value and presents a
//   write-back result to the register-file stage. req_ready stalls EX while an
//   operation is in flight.
//
//   Parameters : TIMEOUT_CYCLES - cycles allowed in REQ+WAIT_R before a bus
//                timeout error (1 .. 65535).
//   Build macro: LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word
//                accesses fault with err_code 01 and never reach memory; when
//                undefined, the low address bits a width cannot use are ignored.
//
//   Ports:
//     clk, rst_n                      clock, asynchronous active-low reset
//     req_valid/req_ready             EX handshake
//     req_is_store, req_funct3,
//     req_addr, req_wdata, req_rd     operation descriptor
//     mem_req/mem_gnt                 memory request handshake
//     mem_we, mem_addr, mem_be,
//     mem_wdata                       request attributes (stable until grant)
//     mem_rvalid, mem_rdata           read response
//     done, wb_we, wb_rd, wb_data     completion pulse and write-back
//     err, err_code                   fault flag (with done) and cause
//                                     (00 none, 01 misaligned, 10 illegal
//                                     funct3, 11 bus timeout)

module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        req_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;

  // Accept-time decode
  logic        illegal;
  logic        misalign;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;

  always_comb begin
    illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
              (req_is_store && req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_funct3[1:0])
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = (req_addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
`else
    misalign = 1'b0;
`endif
    case (req_funct3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << req_addr[1:0];
        wdata_n = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_n    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{req_wdata[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = req_wdata;
      end
    endcase
  end

  // Load extraction from the returned word
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ext;

  always_comb begin
    case (addr_q[1:0])
      2'b00:   rbyte = mem_rdata[7:0];
      2'b01:   rbyte = mem_rdata[15:8];
      2'b10:   rbyte = mem_rdata[23:16];
      default: rbyte = mem_rdata[31:24];
    endcase
    rhalf = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ext = {{24{rbyte[7]}}, rbyte};
      3'b001:  ext = {{16{rhalf[15]}}, rhalf};
      3'b100:  ext = {24'd0, rbyte};
      3'b101:  ext = {16'd0, rhalf};
      default: ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_store_d = req_is_store;
          funct3_d   = req_funct3;
          addr_d     = req_addr;
          be_d       = be_n;
          wdata_d    = wdata_n;
          rd_d       = req_rd;
          cnt_d      = '0;
          if (illegal) begin
            state_d    = DONE;
            err_d      = 1'b1;
            err_code_d = 2'b10;
            wb_rd_d    = req_rd;
          end else if (misalign) begin
            state_d    = DONE;
            err_d      = 1'b1;
            err_code_d = 2'b01;
            wb_rd_d    = req_rd;
          end else begin
            state_d = REQ;
            err_d   = 1'b0;
          end
        end
      end
      REQ: begin
        // A grant in the expiry cycle still counts as progress.
        if (mem_gnt) begin
          if (is_store_q) begin
            state_d    = DONE;
            err_code_d = 2'b00;
            wb_rd_d    = rd_q;
          end else begin
            state_d = WAIT_R;
            cnt_d   = cnt_q + 16'd1;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d    = DONE;
          err_d      = 1'b1;
          err_code_d = 2'b11;
          wb_rd_d    = rd_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          state_d    = DONE;
          wb_data_d  = ext;
          err_code_d = 2'b00;
          wb_rd_d    = rd_q;
        end else if (cnt_q == TO_LAST) begin
          state_d    = DONE;
          err_d      = 1'b1;
          err_code_d = 2'b11;
          wb_rd_d    = rd_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

  // req_ready is gated by rst_n so every output reads 0 while reset is held.
  assign req_ready = rst_n && (state_q == IDLE);
  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_req && is_store_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign done      = (state_q == DONE);
  assign err       = done && err_q;
  assign wb_we     = done && !is_store_q && !err_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign err_code  = err_code_q;

endmodule
